// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: oversamples sclk/lrck/sdata on clk and deserializes each channel slot into a
// parallel sample with a one-cycle strobe. Define I2S_RX_ERR_EN to add the short-slot counter.
module i2s_rx_deserializer #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2s_sclk,
  input  logic                  i2s_lrck,
  input  logic                  i2s_sdata,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_right,
  output logic                  rx_valid
`ifdef I2S_RX_ERR_EN
  ,
  output logic [7:0]            rx_err_count
`endif
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_lrck_sync;
  logic [SYNC_STAGES-1:0] r_sdata_sync;
  logic                   r_sclk_d;

  state_t                 r_state;
  state_t                 w_state_n;
  // The oldest bit drops out on the completing shift, so DATA_WIDTH-1 stored bits suffice.
  logic [DATA_WIDTH-2:0]  r_sr;
  logic [DATA_WIDTH-2:0]  w_sr_n;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_n;
  logic                   r_lrck_prev;
  logic                   w_prev_n;
  logic                   r_ch;
  logic                   w_ch_n;
  logic                   w_emit;

  logic [DATA_WIDTH-1:0]  r_rx_data;
  logic                   r_rx_right;
  logic                   r_rx_valid;

  logic                   w_sclk;
  logic                   w_lrck;
  logic                   w_sdata;
  logic                   w_rise;
  logic                   w_lr_chg;
  logic [DATA_WIDTH-1:0]  w_sr_shift;
  logic [CW-1:0]          w_cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync  <= '0;
      r_lrck_sync  <= '0;
      r_sdata_sync <= '0;
      r_sclk_d     <= 1'b0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], i2s_sclk};
      r_lrck_sync  <= {r_lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], i2s_sdata};
      r_sclk_d     <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
  assign w_lrck     = r_lrck_sync[SYNC_STAGES-1];
  assign w_sdata    = r_sdata_sync[SYNC_STAGES-1];
  assign w_rise     = w_sclk & ~r_sclk_d;
  assign w_lr_chg   = (w_lrck != r_lrck_prev);
  assign w_sr_shift = {r_sr, w_sdata};
  assign w_cnt_inc  = r_cnt + CW'(1);

  always_comb begin
    w_state_n = r_state;
    w_sr_n    = r_sr;
    w_cnt_n   = r_cnt;
    w_prev_n  = r_lrck_prev;
    w_ch_n    = r_ch;
    w_emit    = 1'b0;
    if (w_rise) begin
      case (r_state)
        ST_IDLE: begin
          w_prev_n  = w_lrck;
          w_state_n = ST_ARM;
        end
        ST_ARM: begin
          if (w_lr_chg) begin
            w_ch_n    = w_lrck;
            w_cnt_n   = '0;
            w_prev_n  = w_lrck;
            w_state_n = ST_SHIFT;
          end else begin
            w_state_n = ST_ARM;
          end
        end
        ST_SHIFT: begin
          w_sr_n  = w_sr_shift[DATA_WIDTH-2:0];
          w_cnt_n = w_cnt_inc;
          if (w_cnt_inc == CW'(DATA_WIDTH)) begin
            w_emit    = 1'b1;
            w_state_n = ST_HOLD;
          end else begin
            w_state_n = ST_SHIFT;
          end
          // The shifted bit closes the old slot before a channel change restarts the count.
          if (w_lr_chg) begin
            w_cnt_n   = '0;
            w_ch_n    = w_lrck;
            w_prev_n  = w_lrck;
            w_state_n = ST_SHIFT;
          end else begin
            w_prev_n  = r_lrck_prev;
          end
        end
        ST_HOLD: begin
          if (w_lr_chg) begin
            w_cnt_n   = '0;
            w_ch_n    = w_lrck;
            w_prev_n  = w_lrck;
            w_state_n = ST_SHIFT;
          end else begin
            w_state_n = ST_HOLD;
          end
        end
        default: begin
          w_state_n = ST_IDLE;
        end
      endcase
    end else begin
      w_state_n = r_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_lrck_prev <= 1'b0;
      r_ch        <= 1'b0;
      r_rx_data   <= '0;
      r_rx_right  <= 1'b0;
      r_rx_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_sr        <= w_sr_n;
      r_cnt       <= w_cnt_n;
      r_lrck_prev <= w_prev_n;
      r_ch        <= w_ch_n;
      r_rx_valid  <= w_emit;
      if (w_emit) begin
        r_rx_data  <= w_sr_shift;
        r_rx_right <= r_ch;
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_right = r_rx_right;
  assign rx_valid = r_rx_valid;

`ifdef I2S_RX_ERR_EN
  logic       w_short;
  logic [7:0] r_err_cnt;

  assign w_short = w_rise && (r_state == ST_SHIFT) && w_lr_chg && (w_cnt_inc != CW'(DATA_WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= 8'd0;
    end else if (w_short && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign rx_err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer: slot-level stimulus tables expanded to an I2S pin stream,
// expected samples derived from slot widths/values and reset position.
module tb_i2s_rx_deserializer;

  localparam int DW   = 24;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i2s_sclk = 1'b0;
  logic          i2s_lrck = 1'b0;
  logic          i2s_sdata = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_right;
  logic          rx_valid;
`ifdef I2S_RX_ERR_EN
  logic [7:0]    rx_err_count;
`endif

  i2s_rx_deserializer #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .i2s_sclk  (i2s_sclk),
    .i2s_lrck  (i2s_lrck),
    .i2s_sdata (i2s_sdata),
    .rx_data   (rx_data),
    .rx_right  (rx_right),
    .rx_valid  (rx_valid)
`ifdef I2S_RX_ERR_EN
    ,
    .rx_err_count (rx_err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int            slot_n[$];
  bit            slot_l[$];
  logic [DW-1:0] slot_w[$];
  bit            lr_a[$];
  bit            sd_a[$];
  int            rise_cyc[$];
  logic [DW-1:0] exp_d[$];
  bit            exp_r[$];
  int            exp_rise[$];
  int            exp_err;
  logic [DW-1:0] cap_d[$];
  bit            cap_r[$];
  int            cap_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      cap_d.push_back(rx_data);
      cap_r.push_back(rx_right);
      cap_t.push_back(cyc);
    end
  end

  function automatic void clear_slots();
    slot_n.delete(); slot_l.delete(); slot_w.delete();
  endfunction

  function automatic void add_slot(bit l, int n, logic [DW-1:0] w);
    slot_n.push_back(n); slot_l.push_back(l); slot_w.push_back(w);
  endfunction

  // Expand slots into per-rise lrck/sdata: slot MSB one rise after its lrck edge.
  function automatic void build_stream();
    int total = 0;
    int s = 0;
    logic [DW-1:0] w;
    foreach (slot_n[j]) total += slot_n[j];
    lr_a.delete(); sd_a.delete(); rise_cyc.delete();
    for (int i = 0; i <= total; i++) begin
      lr_a.push_back(1'b0); sd_a.push_back(1'b0); rise_cyc.push_back(0);
    end
    foreach (slot_n[j]) begin
      w = slot_w[j];
      for (int k = 0; k < slot_n[j]; k++) begin
        lr_a[s+k] = slot_l[j];
        if (k < DW) sd_a[s+1+k] = w[DW-1-k];
      end
      s += slot_n[j];
    end
    lr_a[total] = slot_l[slot_l.size()-1];
  endfunction

  // Slot-level expectation: a slot after the first observed lrck edge yields a sample when it
  // carries at least DW bits; a reset between rises r and r+1 loses slots starting before r+2.
  function automatic void model(int rst_at);
    int s = 0;
    int t = lr_a.size();
    int nerr = 0;
    bit ok;
    exp_d.delete(); exp_r.delete(); exp_rise.delete();
    foreach (slot_n[j]) begin
      ok = (rst_at < 0) || (s >= rst_at + 2);
      if (j >= 1) begin
        if (slot_n[j] >= DW && s + DW <= t - 1 && (ok || s + DW <= rst_at)) begin
          exp_d.push_back(slot_w[j]); exp_r.push_back(slot_l[j]); exp_rise.push_back(s + DW);
        end
        if (slot_n[j] < DW && j < slot_n.size() - 1 && ok) nerr++;
      end
      s += slot_n[j];
    end
    exp_err = (nerr > 255) ? 255 : nerr;
  endfunction

  task automatic run_stream(input int first, input int last);
    for (int t = first; t <= last; t++) begin
      @(negedge clk);
      i2s_sclk = 1'b0; i2s_lrck = lr_a[t]; i2s_sdata = sd_a[t];
      repeat (4) @(negedge clk);
      i2s_sclk = 1'b1;
      rise_cyc[t] = cyc;
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    i2s_sclk = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i2s_sclk = 1'b0; i2s_lrck = 1'b0; i2s_sdata = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cap_d.delete(); cap_r.delete(); cap_t.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rx_data !== '0 || rx_valid !== 1'b0 || rx_right !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got data=%h valid=%b right=%b, expected 0/0/0", rx_data, rx_valid, rx_right);
    end
`ifdef I2S_RX_ERR_EN
    checks++;
    if (rx_err_count !== 8'd0) begin
      errors++; $display("FAIL reset_err: got %0d expected 0", rx_err_count);
    end
`endif
  endtask

  task automatic test_basic();
    int lat;
    do_reset();
    clear_slots();
    add_slot(1'b1, 32, 24'h000000);
    add_slot(1'b0, 32, 24'h123456);
    add_slot(1'b1, 32, 24'hABCDEF);
    add_slot(1'b0, 32, 24'h800001);
    add_slot(1'b1, 32, 24'h7FFFFF);
    build_stream(); model(-1);
    run_stream(0, lr_a.size() - 1);
    checks++;
    if (cap_d.size() != exp_d.size()) begin
      errors++; $display("FAIL basic_count: got %0d strobes expected %0d", cap_d.size(), exp_d.size());
    end else begin
      for (int i = 0; i < exp_d.size(); i++) begin
        checks++;
        if (cap_d[i] !== exp_d[i] || cap_r[i] !== exp_r[i]) begin
          errors++; $display("FAIL basic_sample[%0d]: got %h/%b expected %h/%b", i, cap_d[i], cap_r[i], exp_d[i], exp_r[i]);
        end
        checks++; lat = cap_t[i] - rise_cyc[exp_rise[i]];
        if (lat < SYNC + 1 || lat > SYNC + 3) begin
          errors++; $display("FAIL basic_latency[%0d]: got %0d expected %0d..%0d", i, lat, SYNC + 1, SYNC + 3);
        end
      end
    end
    checks++;
    if (rx_data !== 24'h7FFFFF || rx_valid !== 1'b0) begin
      errors++; $display("FAIL basic_hold: got %h/%b expected 7fffff/0", rx_data, rx_valid);
    end
  endtask

  task automatic test_exact_width();
    do_reset();
    clear_slots();
    add_slot(1'b1, DW, 24'h000000);
    for (int f = 0; f < 4; f++) begin
      add_slot(1'b0, DW, 24'hA5A5A5);
      add_slot(1'b1, DW, 24'h5A5A5A);
    end
    build_stream(); model(-1);
    run_stream(0, lr_a.size() - 1);
    checks++;
    if (cap_d.size() != exp_d.size() || exp_d.size() != 8) begin
      errors++; $display("FAIL exact_count: got %0d strobes expected 8", cap_d.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (cap_d[i] !== exp_d[i] || cap_r[i] !== exp_r[i]) begin
          errors++; $display("FAIL exact_sample[%0d]: got %h/%b expected %h/%b", i, cap_d[i], cap_r[i], exp_d[i], exp_r[i]);
        end
        if (i > 0) begin
          checks++;
          if (cap_t[i] - cap_t[i-1] != DW * 8) begin
            errors++; $display("FAIL exact_spacing[%0d]: got %0d clks expected %0d", i, cap_t[i] - cap_t[i-1], DW * 8);
          end
        end
      end
    end
  endtask

  task automatic test_short_slot();
    do_reset();
    clear_slots();
    add_slot(1'b1, 32, 24'h000000);
    add_slot(1'b0, 32, 24'($urandom));
    add_slot(1'b1, 16, 24'hFFFF00);
    add_slot(1'b0, 32, 24'($urandom));
    add_slot(1'b1, 32, 24'($urandom));
    build_stream(); model(-1);
    run_stream(0, lr_a.size() - 1);
    checks++;
    if (cap_d.size() != exp_d.size()) begin
      errors++; $display("FAIL short_count: got %0d strobes expected %0d", cap_d.size(), exp_d.size());
    end else begin
      for (int i = 0; i < exp_d.size(); i++) begin
        checks++;
        if (cap_d[i] !== exp_d[i] || cap_r[i] !== exp_r[i]) begin
          errors++; $display("FAIL short_sample[%0d]: got %h/%b expected %h/%b", i, cap_d[i], cap_r[i], exp_d[i], exp_r[i]);
        end
      end
    end
`ifdef I2S_RX_ERR_EN
    checks++;
    if (rx_err_count !== 8'(exp_err)) begin
      errors++; $display("FAIL short_err: got %0d expected %0d", rx_err_count, exp_err);
    end
`endif
  endtask

  task automatic test_err_saturate();
    do_reset();
    clear_slots();
    add_slot(1'b1, 32, 24'h000000);
    for (int i = 0; i < 300; i++) add_slot(i[0] ? 1'b1 : 1'b0, 2, 24'($urandom));
    build_stream(); model(-1);
    run_stream(0, lr_a.size() - 1);
    checks++;
    if (cap_d.size() != 0) begin
      errors++; $display("FAIL sat_strobes: got %0d strobes expected 0", cap_d.size());
    end
`ifdef I2S_RX_ERR_EN
    checks++;
    if (rx_err_count !== 8'(exp_err)) begin
      errors++; $display("FAIL sat_err: got %0d expected %0d", rx_err_count, exp_err);
    end
`endif
  endtask

  task automatic test_reset_midword();
    int r;
    do_reset();
    clear_slots();
    add_slot(1'b1, 32, 24'h000000);
    add_slot(1'b0, 32, 24'($urandom));
    add_slot(1'b1, 32, 24'($urandom));
    add_slot(1'b0, 32, 24'($urandom));
    build_stream();
    r = 32 + 10;
    model(r);
    run_stream(0, r);
    @(negedge clk) i2s_sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    checks++;
    if (rx_data !== '0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state: got %h/%b expected 0/0", rx_data, rx_valid);
    end
    run_stream(r + 1, lr_a.size() - 1);
    checks++;
    if (cap_d.size() != exp_d.size()) begin
      errors++; $display("FAIL midrst_count: got %0d strobes expected %0d", cap_d.size(), exp_d.size());
    end else begin
      for (int i = 0; i < exp_d.size(); i++) begin
        checks++;
        if (cap_d[i] !== exp_d[i] || cap_r[i] !== exp_r[i]) begin
          errors++; $display("FAIL midrst_sample[%0d]: got %h/%b expected %h/%b", i, cap_d[i], cap_r[i], exp_d[i], exp_r[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int lat;
    do_reset();
    clear_slots();
    add_slot(1'b1, 32, 24'h000000);
    for (int i = 0; i < 14; i++)
      add_slot(i[0] ? 1'b1 : 1'b0,
               ($urandom_range(0, 4) == 0) ? $urandom_range(1, DW - 1) : $urandom_range(DW, 32),
               24'($urandom));
    build_stream(); model(-1);
    run_stream(0, lr_a.size() - 1);
    checks++;
    if (cap_d.size() != exp_d.size()) begin
      errors++; $display("FAIL rand_count: got %0d strobes expected %0d", cap_d.size(), exp_d.size());
    end else begin
      for (int i = 0; i < exp_d.size(); i++) begin
        checks++;
        if (cap_d[i] !== exp_d[i] || cap_r[i] !== exp_r[i]) begin
          errors++; $display("FAIL rand_sample[%0d]: got %h/%b expected %h/%b", i, cap_d[i], cap_r[i], exp_d[i], exp_r[i]);
        end
        checks++; lat = cap_t[i] - rise_cyc[exp_rise[i]];
        if (lat < SYNC + 1 || lat > SYNC + 3) begin
          errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d..%0d", i, lat, SYNC + 1, SYNC + 3);
        end
      end
    end
`ifdef I2S_RX_ERR_EN
    checks++;
    if (rx_err_count !== 8'(exp_err)) begin
      errors++; $display("FAIL rand_err: got %0d expected %0d", rx_err_count, exp_err);
    end
`endif
  endtask

  task automatic test_latency();
    int lat;
    bit early;
    logic [DW-1:0] w;
    do_reset();
    w = 24'($urandom);
    clear_slots();
    add_slot(1'b1, 32, 24'h000000);
    add_slot(1'b0, 32, w);
    build_stream();
    run_stream(0, 32 + DW - 1);
    early = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rx_valid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early || rx_data !== '0) begin
      errors++; $display("FAIL lat_stopped: got early=%b data=%h expected 0/0", early, rx_data);
    end
    @(negedge clk);
    i2s_lrck = lr_a[32 + DW]; i2s_sdata = sd_a[32 + DW];
    repeat (4) @(negedge clk);
    i2s_sclk = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rx_valid !== 1'b1 && lat < 12);
    checks++;
    if (lat < SYNC + 1 || lat > SYNC + 3) begin
      errors++; $display("FAIL lat_cycles: got %0d expected %0d..%0d", lat, SYNC + 1, SYNC + 3);
    end
    checks++;
    if (rx_data !== w || rx_right !== 1'b0) begin
      errors++; $display("FAIL lat_sample: got %h/%b expected %h/0", rx_data, rx_right, w);
    end
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL lat_width: got valid=%b on second cycle expected 0", rx_valid);
    end
    i2s_sclk = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exact_width();
    test_short_slot();
    test_err_saturate();
    test_reset_midword();
    test_random();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
